truth_table_sequencer: RTL and testbench

- Sweeps an N_IN-bit input vector through every combination, from 0 to 2^N_IN-1.
- For each combination, waits a programmable settle time, then compares two single-bit results from gate-level implementations driven by that vector.
- Counts mismatches and records the first failing vector.
- Sits beside paired gate-equivalence modules, e.g. the structural vs. dataflow forms of a two-input implication function, and replaces hand-written stimulus sequences.

---
 rtl/ttseq_pkg.sv | 23 ++
 rtl/ttseq_settle_timer.sv | 35 +++
 rtl/truth_table_sequencer.sv | 150 +++++++++++++++
 tb/tb_truth_table_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttseq_pkg.sv
// ttseq_pkg: shared types and helpers for the truth-table sequencer.
//   ttseq_state_t : sequencer FSM state encoding (2 bits)
//   SETTLE_W      : width of the settle down-counter (holds up to 15)
//   last_vec()    : all-ones terminal vector for a given input width
package ttseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } ttseq_state_t;

  localparam int SETTLE_W = 4;

  // Terminal vector of a sweep: n ones in the low bits (n is 1..8).
  function automatic logic [7:0] last_vec(input int unsigned n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

endpackage

// File: rtl/ttseq_settle_timer.sv
// ttseq_settle_timer: settle-time down-counter for the sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load counter with load_val (has priority over dec)
//   load_val   : value loaded on load
//   dec        : decrement by one while non-zero
//   zero       : counter currently equals zero
module ttseq_settle_timer
  import ttseq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt_r;

  // Down-counter register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - {{(SETTLE_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps in_vec through 0..2^N_IN-1, holds each vector
// for SETTLE cycles, then compares res_a against res_b and counts mismatches.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begins a sweep when idle
//   in_vec        : vector driven to both implementations under test
//   res_a, res_b  : results of the two implementations
//   busy, done    : sweep in progress / one-cycle completion pulse
//   mismatch_cnt  : number of mismatching vectors in the last sweep
//   first_bad     : first mismatching vector (meaningful when err=1)
//   err           : at least one mismatch in the last sweep
// Build option: define TTSEQ_STOP_ON_MISMATCH_EN to end the sweep at the first
// mismatch, leaving in_vec on the failing vector.
module truth_table_sequencer
  import ttseq_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] in_vec,
  input  logic            res_a,
  input  logic            res_b,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_bad,
  output logic            err
);

  localparam logic [7:0]          LAST_FULL   = last_vec(N_IN);
  localparam logic [N_IN-1:0]     LAST_VEC    = LAST_FULL[N_IN-1:0];
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]     VEC_ONE     = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]       CNT_ONE     = {{N_IN{1'b0}}, 1'b1};

  ttseq_state_t    state_r, state_s;
  logic [N_IN-1:0] vec_r, vec_s;
  logic [N_IN:0]   cnt_r, cnt_s;
  logic [N_IN-1:0] first_bad_r, first_bad_s;
  logic            err_r, err_s;
  logic            done_r, busy_r;
  logic            load_s, dec_s, zero_s, mismatch_s, stop_s;

  ttseq_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (SETTLE_LOAD),
    .dec      (dec_s),
    .zero     (zero_s)
  );

  assign mismatch_s = res_a ^ res_b;

  // Next-state, vector and result-register logic.
  always_comb begin
    state_s     = state_r;
    vec_s       = vec_r;
    cnt_s       = cnt_r;
    first_bad_s = first_bad_r;
    err_s       = err_r;
    load_s      = 1'b0;
    dec_s       = 1'b0;
`ifdef TTSEQ_STOP_ON_MISMATCH_EN
    stop_s      = mismatch_s;
`else
    stop_s      = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          vec_s       = '0;
          cnt_s       = '0;
          first_bad_s = '0;
          err_s       = 1'b0;
          load_s      = 1'b1;
          state_s     = ST_SETTLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (zero_s) begin
          state_s = ST_SAMPLE;
        end else begin
          dec_s = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch_s) begin
          cnt_s = cnt_r + CNT_ONE;
          if (!err_r) begin
            first_bad_s = vec_r;
            err_s       = 1'b1;
          end else begin
            first_bad_s = first_bad_r;
          end
        end else begin
          cnt_s = cnt_r;
        end
        // Terminal test is against all-ones so in_vec never wraps.
        if ((vec_r == LAST_VEC) || stop_s) begin
          state_s = ST_FINISH;
        end else begin
          vec_s   = vec_r + VEC_ONE;
          load_s  = 1'b1;
          state_s = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        // start here is deliberately not looked at.
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and result registers; done/busy are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      vec_r       <= '0;
      cnt_r       <= '0;
      first_bad_r <= '0;
      err_r       <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      vec_r       <= vec_s;
      cnt_r       <= cnt_s;
      first_bad_r <= first_bad_s;
      err_r       <= err_s;
      done_r      <= (state_s == ST_FINISH);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign in_vec       = vec_r;
  assign mismatch_cnt = cnt_r;
  assign first_bad    = first_bad_r;
  assign err          = err_r;
  assign done         = done_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

  typedef struct {
    int unsigned start_cyc;
    int unsigned lat;
    int unsigned cnt;
    int unsigned err;
    int unsigned fb;
    int unsigned vec;
  } exp_t;

  logic       clk, rst_n, start, start3, mode;
  logic [1:0] in_vec, first_bad, in_vec3, first_bad3;
  logic [2:0] mismatch_cnt, mismatch_cnt3;
  logic       res_a, res_b, busy, done, err;
  logic       res_a3, res_b3, busy3, done3, err3;

  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  exp_t q_a[$];
  exp_t q_3[$];

  // Case 1 expectations depend on the stop-on-mismatch build option.
`ifdef TTSEQ_STOP_ON_MISMATCH_EN
  localparam int unsigned C1_LAT = 5, C1_CNT = 1, C1_VEC = 1;
`else
  localparam int unsigned C1_LAT = 9, C1_CNT = 2, C1_VEC = 3;
`endif

  truth_table_sequencer #(.N_IN(2), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec),
    .res_a(res_a), .res_b(res_b), .busy(busy), .done(done),
    .mismatch_cnt(mismatch_cnt), .first_bad(first_bad), .err(err)
  );

  truth_table_sequencer #(.N_IN(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .in_vec(in_vec3),
    .res_a(res_a3), .res_b(res_b3), .busy(busy3), .done(done3),
    .mismatch_cnt(mismatch_cnt3), .first_bad(first_bad3), .err(err3)
  );

  // Implementations under comparison: x = in_vec[1], y = in_vec[0].
  // mode 0: A = ~x|y, B = x|~y ; mode 1: A = B = ~x|y
  assign res_a  = ~in_vec[1] | in_vec[0];
  assign res_b  = mode ? (~in_vec[1] | in_vec[0]) : (in_vec[1] | ~in_vec[0]);
  assign res_a3 = ~in_vec3[1] | in_vec3[0];
  assign res_b3 = ~in_vec3[1] | in_vec3[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_done(input string tag, input exp_t e, input int unsigned now,
                              input int unsigned cnt, input int unsigned er,
                              input int unsigned fb, input int unsigned vec);
    chk({tag, "_latency"}, now - e.start_cyc, e.lat);
    chk({tag, "_mismatch_cnt"}, cnt, e.cnt);
    chk({tag, "_err"}, er, e.err);
    chk({tag, "_first_bad"}, fb, e.fb);
    chk({tag, "_in_vec"}, vec, e.vec);
  endtask

  // Monitor for the SETTLE=1 instance: every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      if (q_a.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        compare_done("dut", q_a.pop_front(), cyc, mismatch_cnt, err, first_bad, in_vec);
      end
    end
  end

  // Monitor for the SETTLE=3 instance.
  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q_3.size() == 0) begin
        chk("done3_unexpected", 1, 0);
      end else begin
        compare_done("dut3", q_3.pop_front(), cyc, mismatch_cnt3, err3, first_bad3, in_vec3);
      end
    end
  end

  // Pulse start for one cycle on the default instance; optionally queue an expectation.
  task automatic issue_a(input bit push, input exp_t e);
    @(negedge clk);
    start = 1'b1;
    e.start_cyc = cyc;
    if (push) q_a.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 40 && q_a.size() != 0; i++) @(negedge clk);
    if (q_a.size() != 0) begin
      chk("done_timeout", 0, 1);
      q_a.delete();
    end
  endtask

  task automatic wait_3();
    for (int i = 0; i < 60 && q_3.size() != 0; i++) @(negedge clk);
    if (q_3.size() != 0) begin
      chk("done3_timeout", 0, 1);
      q_3.delete();
    end
  endtask

  initial begin
    exp_t e1, e2, e3;
    int   ds;
    e1 = '{0, C1_LAT, C1_CNT, 1, 1, C1_VEC};
    e2 = '{0, 9, 0, 0, 0, 3};
    e3 = '{0, 17, 0, 0, 0, 3};

    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_in_vec", in_vec, 0);
    chk("rst_mismatch_cnt", mismatch_cnt, 0);
    chk("rst_first_bad", first_bad, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Case 1 (case 5 under the stop option): mismatching implementations
    mode = 1'b0;
    issue_a(1'b1, e1);
    chk("c1_busy", busy, 1);
    wait_a();

    // Case 6: results hold through IDLE, next start clears them
    repeat (3) @(negedge clk);
    chk("hold_busy", busy, 0);
    chk("hold_cnt", mismatch_cnt, C1_CNT);
    chk("hold_err", err, 1);
    chk("hold_first_bad", first_bad, 1);
    chk("hold_in_vec", in_vec, C1_VEC);
    mode = 1'b1;
    issue_a(1'b1, e2);
    chk("clr_cnt", mismatch_cnt, 0);
    chk("clr_err", err, 0);
    chk("clr_first_bad", first_bad, 0);
    chk("clr_in_vec", in_vec, 0);
    wait_a();

    // Case 2 with a start landing on the done cycle (must be ignored)
    repeat (2) @(negedge clk);
    issue_a(1'b1, e2);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_done_busy", busy, 0);
    @(negedge clk);
    chk("start_on_done_busy2", busy, 0);
    chk("start_on_done_done", done, 0);
    wait_a();

    // Case 3: SETTLE=3, each vector k held on cycles 4k+1 .. 4k+4
    @(negedge clk);
    start3 = 1'b1;
    e3.start_cyc = cyc;
    q_3.push_back(e3);
    @(negedge clk);
    start3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        chk("c3_in_vec_hold", in_vec3, k);
        @(negedge clk);
      end
    end
    wait_3();

    // Case 4: start while busy ignored, reset mid-sweep, no done afterwards
    mode = 1'b0;
    repeat (2) @(negedge clk);
    issue_a(1'b0, e1);          // now in cycle 1
    @(negedge clk);             // cycle 2
    @(negedge clk);             // cycle 3
    start = 1'b1;
    @(negedge clk);             // cycle 4: SAMPLE of vector 1 if no restart
    start = 1'b0;
    chk("c4_busy", busy, 1);
    chk("c4_in_vec_no_restart", in_vec, 1);
    @(negedge clk);             // cycle 5
    chk("c4_cnt_before_rst", mismatch_cnt, 1);
    ds = done_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("c4_async_in_vec", in_vec, 0);
    chk("c4_async_cnt", mismatch_cnt, 0);
    chk("c4_async_first_bad", first_bad, 0);
    chk("c4_async_err", err, 0);
    chk("c4_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("c4_no_done", done_seen, ds);
    chk("c4_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
